// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared types and helpers for the adder stream arbiter
package adder_arb_pkg;

   // Arbiter FSM: IDLE arbitrates (one bubble per packet), XFER passes a locked packet through
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } arb_state_t;

   // Widest requester vector the generic round-robin helper handles
   localparam int RR_MAX_REQ = 16;
   localparam int RR_IDX_W   = 4;

   typedef struct packed {
      logic                found;
      logic [RR_IDX_W-1:0] winner;
   } rr_pick_t;

   // Index width for a count of items; never narrower than one bit
   function automatic int clog2(input int value);
      int result;
      result = 0;
      while ((1 << result) < value) begin
         result = result + 1;
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

   // Reference round-robin pick: lowest valid index at or after ptr, wrapping at num_req
   function automatic rr_pick_t rr_select(input logic [RR_MAX_REQ-1:0] valid_vec,
                                          input logic [RR_IDX_W-1:0]   ptr,
                                          input int                    num_req);
      rr_pick_t pick;
      int       idx;
      pick = '0;
      for (int k = 0; k < RR_MAX_REQ; k++) begin
         idx = (int'(ptr) + k) % num_req;
         if (k < num_req && !pick.found && valid_vec[idx]) begin
            pick.found  = 1'b1;
            pick.winner = idx[RR_IDX_W-1:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// rtl/rr_priority_select.sv - combinational round-robin find-first (rotate, pick, un-rotate)
module rr_priority_select
   import adder_arb_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = clog2(N)
) (
   input  logic [N-1:0]   valid_vec,
   input  logic [IDW-1:0] ptr,
   output logic [IDW-1:0] winner,
   output logic           found
);

   localparam logic [IDW:0] N_EXT = (IDW+1)'(N);

   logic [2*N-1:0] doubled;
   logic [N-1:0]   rotated;
   logic [IDW-1:0] first_idx;
   logic [IDW:0]   sum;

   // Rotate so ptr sits at bit 0, take the lowest set bit, then map back to a requester index
   always_comb begin
      doubled   = {valid_vec, valid_vec} >> ptr;
      rotated   = doubled[N-1:0];
      first_idx = '0;
      found     = 1'b0;
      for (int i = N-1; i >= 0; i--) begin
         if (rotated[i]) begin
            first_idx = i[IDW-1:0];
            found     = 1'b1;
         end
      end
      sum = {1'b0, first_idx} + {1'b0, ptr};
      if (sum >= N_EXT) begin
         sum = sum - N_EXT;
      end
      winner = sum[IDW-1:0];
   end

endmodule

// File: rtl/adder_stream_arbiter.sv
// rtl/adder_stream_arbiter.sv - packet-granular round-robin arbiter feeding one constant adder
module adder_stream_arbiter
   import adder_arb_pkg::*;
#(
   parameter int C_NUM_REQ          = 4,
   parameter int C_AXIS_TDATA_WIDTH = 512,
   parameter int C_ADDER_BIT_WIDTH  = 32,
   parameter int C_ID_WIDTH         = 2
) (
   input  logic                                      aclk,
   input  logic                                      aresetn,
   input  logic [C_NUM_REQ*C_ADDER_BIT_WIDTH-1:0]    req_constant,
   input  logic [C_NUM_REQ-1:0]                      s_axis_tvalid,
   output logic [C_NUM_REQ-1:0]                      s_axis_tready,
   input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [C_NUM_REQ*C_AXIS_TDATA_WIDTH/8-1:0] s_axis_tkeep,
   input  logic [C_NUM_REQ-1:0]                      s_axis_tlast,
   output logic                                      m_axis_tvalid,
   input  logic                                      m_axis_tready,
   output logic [C_AXIS_TDATA_WIDTH-1:0]             m_axis_tdata,
   output logic [C_AXIS_TDATA_WIDTH/8-1:0]           m_axis_tkeep,
   output logic                                      m_axis_tlast,
   output logic [C_ADDER_BIT_WIDTH-1:0]              ctrl_constant,
   output logic [C_ID_WIDTH-1:0]                     grant_id,
   output logic                                      busy
);

   localparam int                    KEEP_W   = C_AXIS_TDATA_WIDTH/8;
   localparam logic [C_ID_WIDTH-1:0] LAST_IDX = C_ID_WIDTH'(C_NUM_REQ-1);

   arb_state_t                    state;
   arb_state_t                    state_nxt;
   logic [C_ID_WIDTH-1:0]         rr_ptr;
   logic [C_ID_WIDTH-1:0]         rr_winner;
   logic                          rr_found;
   logic                          pkt_done;
   logic [C_ID_WIDTH-1:0]         next_ptr;

   logic [C_AXIS_TDATA_WIDTH-1:0] data_arr  [C_NUM_REQ];
   logic [KEEP_W-1:0]             keep_arr  [C_NUM_REQ];
   logic [C_ADDER_BIT_WIDTH-1:0]  const_arr [C_NUM_REQ];

   // Split the flat requester buses into per-requester slices
   for (genvar gi = 0; gi < C_NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi]  = s_axis_tdata[gi*C_AXIS_TDATA_WIDTH +: C_AXIS_TDATA_WIDTH];
      assign keep_arr[gi]  = s_axis_tkeep[gi*KEEP_W +: KEEP_W];
      assign const_arr[gi] = req_constant[gi*C_ADDER_BIT_WIDTH +: C_ADDER_BIT_WIDTH];
   end

   rr_priority_select #(
      .N   (C_NUM_REQ),
      .IDW (C_ID_WIDTH)
   ) u_rr_select (
      .valid_vec (s_axis_tvalid),
      .ptr       (rr_ptr),
      .winner    (rr_winner),
      .found     (rr_found)
   );

   // Packet ends on the accepted tlast beat of the granted requester
   assign pkt_done = (state == ST_XFER) && s_axis_tvalid[grant_id] &&
                     m_axis_tready && s_axis_tlast[grant_id];

   assign next_ptr = (grant_id == LAST_IDX) ? '0 : grant_id + 1'b1;

   // State register
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: lock on a winner, release only after the packet's last beat
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (rr_found) state_nxt = ST_XFER;
         ST_XFER: if (pkt_done) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Grant and constant are captured only at arbitration; pointer advances past the finished requester
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         grant_id      <= '0;
         ctrl_constant <= '0;
         rr_ptr        <= '0;
      end else begin
         if (state == ST_IDLE && rr_found) begin
            grant_id      <= rr_winner;
            ctrl_constant <= const_arr[rr_winner];
         end
         if (pkt_done) begin
            rr_ptr <= next_ptr;
         end
      end
   end

   // Outputs: zero-latency pass-through of the granted requester while in XFER, quiet otherwise
   always_comb begin
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tkeep  = '0;
      m_axis_tlast  = 1'b0;
      s_axis_tready = '0;
      busy          = 1'b0;
      if (state == ST_XFER) begin
         busy                    = 1'b1;
         m_axis_tvalid           = s_axis_tvalid[grant_id];
         m_axis_tdata            = data_arr[grant_id];
         m_axis_tkeep            = keep_arr[grant_id];
         m_axis_tlast            = s_axis_tlast[grant_id];
         s_axis_tready[grant_id] = m_axis_tready;
      end
   end

endmodule

// File: tb/tb_adder_stream_arbiter.sv
// tb/tb_adder_stream_arbiter.sv - randomized self-checking bench for adder_stream_arbiter
module tb_adder_stream_arbiter;

   localparam int N  = 4;
   localparam int DW = 512;
   localparam int KW = DW/8;
   localparam int CW = 32;
   localparam int IW = 2;

   logic            aclk = 1'b0;
   logic            aresetn;
   logic [N*CW-1:0] req_constant;
   logic [N-1:0]    s_axis_tvalid;
   logic [N-1:0]    s_axis_tready;
   logic [N*DW-1:0] s_axis_tdata;
   logic [N*KW-1:0] s_axis_tkeep;
   logic [N-1:0]    s_axis_tlast;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic [DW-1:0]   m_axis_tdata;
   logic [KW-1:0]   m_axis_tkeep;
   logic            m_axis_tlast;
   logic [CW-1:0]   ctrl_constant;
   logic [IW-1:0]   grant_id;
   logic            busy;

   always #5 aclk = ~aclk;

   adder_stream_arbiter #(
      .C_NUM_REQ          (N),
      .C_AXIS_TDATA_WIDTH (DW),
      .C_ADDER_BIT_WIDTH  (CW),
      .C_ID_WIDTH         (IW)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .req_constant  (req_constant),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tlast  (m_axis_tlast),
      .ctrl_constant (ctrl_constant),
      .grant_id      (grant_id),
      .busy          (busy)
   );

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
   } beat_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [KW-1:0] keep;
      logic          last;
      logic [IW-1:0] gid;
      logic [CW-1:0] cst;
   } obs_t;

   beat_t         txq [N][$];
   obs_t          exp_q[$];
   obs_t          obs_q[$];
   logic [CW-1:0] const_arr [N];
   logic [0:3]    rdy_pat = 4'b1001;
   int            model_ptr;
   int            model_pkts;
   int            checks = 0;
   int            errors = 0;
   int            cyc_count, idle_leak, stray_ready, offer_err;
   int            chg_at = -1;
   logic [CW-1:0] chg_val;
   int            tick = 0;

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int w = 0; w < DW/32; w++) d[w*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic add_pkt(input int r, input int len);
      beat_t b;
      for (int k = 0; k < len; k++) begin
         b.data = rand_data();
         b.keep = {$urandom, $urandom};
         b.last = (k == len-1);
         txq[r].push_back(b);
      end
   endtask

   // Reference: every queued packet is pending from the start; each arbitration picks the first
   // non-empty requester at or after the pointer and forwards that whole packet with its constant.
   task automatic model_build();
      beat_t refq [N][$];
      beat_t b;
      obs_t  e;
      int    w;
      exp_q.delete();
      model_pkts = 0;
      for (int i = 0; i < N; i++) refq[i] = txq[i];
      while (1) begin
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && refq[(model_ptr+k)%N].size() > 0) w = (model_ptr+k)%N;
         if (w < 0) break;
         do begin
            b = refq[w].pop_front();
            e = {b.data, b.keep, b.last, IW'(w), const_arr[w]};
            exp_q.push_back(e);
         end while (!b.last);
         model_pkts++;
         model_ptr = (w+1) % N;
      end
   endtask

   task automatic drive_inputs(input int mode);
      for (int i = 0; i < N; i++) begin
         req_constant[i*CW +: CW] = const_arr[i];
         if (txq[i].size() > 0) begin
            s_axis_tvalid[i]         = 1'b1;
            s_axis_tdata[i*DW +: DW] = txq[i][0].data;
            s_axis_tkeep[i*KW +: KW] = txq[i][0].keep;
            s_axis_tlast[i]          = txq[i][0].last;
         end else begin
            s_axis_tvalid[i]         = 1'b0;
            s_axis_tdata[i*DW +: DW] = rand_data();
            s_axis_tkeep[i*KW +: KW] = '0;
            s_axis_tlast[i]          = 1'($urandom_range(0, 1));
         end
      end
      case (mode)
         0:       m_axis_tready = 1'b1;
         1:       m_axis_tready = rdy_pat[tick%4];
         default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
      tick++;
   endtask

   // Stimulus engine: presents queued beats, records accepted beats and per-cycle bus anomalies
   task automatic run_engine(input int mode, input int target, input int budget);
      logic [N-1:0] hs;
      int           g;
      obs_t         e;
      cyc_count = 0; idle_leak = 0; stray_ready = 0; offer_err = 0;
      obs_q.delete();
      drive_inputs(mode);
      while (obs_q.size() < target && cyc_count < budget) begin
         @(negedge aclk);
         cyc_count++;
         hs = s_axis_tvalid & s_axis_tready;
         e  = exp_q[obs_q.size()];
         g  = int'(e.gid);
         if (!busy) begin
            if (m_axis_tvalid || m_axis_tlast || (|m_axis_tdata) || (|m_axis_tkeep) || (|s_axis_tready))
               idle_leak++;
         end else begin
            if (s_axis_tready !== ({{(N-1){1'b0}}, m_axis_tready} << g)) stray_ready++;
            if (m_axis_tvalid && ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, grant_id, ctrl_constant} !== e))
               offer_err++;
         end
         if (m_axis_tvalid && m_axis_tready)
            obs_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast, grant_id, ctrl_constant});
         @(posedge aclk);
         #1;
         for (int i = 0; i < N; i++) if (hs[i]) void'(txq[i].pop_front());
         if (chg_at >= 0 && obs_q.size() == chg_at) begin
            const_arr[0] = chg_val;
            chg_at = -1;
         end
         drive_inputs(mode);
      end
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      for (int i = 0; i < N; i++) txq[i].delete();
      drive_inputs(0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      model_ptr = 0;
   endtask

   task automatic test_reset();
      aresetn = 1'b0;
      for (int i = 0; i < N; i++) begin
         txq[i].delete();
         const_arr[i] = $urandom;
      end
      drive_inputs(0);
      s_axis_tvalid = '1;
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      checks++;
      if ({m_axis_tvalid, s_axis_tready, busy, grant_id, m_axis_tlast} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: tvalid=%b s_tready=%b busy=%b grant=%0d tlast=%b, all required 0",
                  m_axis_tvalid, s_axis_tready, busy, grant_id, m_axis_tlast);
      end
      checks++;
      if (ctrl_constant !== '0 || m_axis_tdata !== '0 || dut.rr_ptr !== '0) begin
         errors++;
         $display("FAIL reset_regs: ctrl=%h rr_ptr=%0d tdata_nz=%b, required 0", ctrl_constant, dut.rr_ptr, |m_axis_tdata);
      end
      @(posedge aclk);
      #1;
      drive_inputs(0);
      aresetn   = 1'b1;
      model_ptr = 0;
   endtask

   task automatic test_single_requester();
      logic [DW-1:0] d;
      beat_t         b;
      for (int i = 0; i < N; i++) const_arr[i] = $urandom;
      const_arr[1] = 32'd5;
      for (int k = 0; k < 3; k++) begin
         d      = '0;
         d[7:0] = 8'(16*(k+1));
         b.data = d;
         b.keep = {$urandom, $urandom};
         b.last = (k == 2);
         txq[1].push_back(b);
      end
      model_build();
      run_engine(0, exp_q.size(), 50);
      checks++;
      if (obs_q.size() !== 3) begin
         errors++; $display("FAIL single_count: got %0d beats, required 3", obs_q.size());
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            errors++; $display("FAIL single_beat%0d: got %h required %h", k, obs_q[k], exp_q[k]);
         end
      end
      checks++;
      if (cyc_count !== 4) begin
         errors++; $display("FAIL single_cycles: got %0d cycles, required 4 (one bubble + 3 beats)", cyc_count);
      end
      checks++;
      if (dut.rr_ptr !== 2'd2 || busy !== 1'b0) begin
         errors++; $display("FAIL single_end: rr_ptr=%0d busy=%b, required rr_ptr=2 busy=0", dut.rr_ptr, busy);
      end
      checks++;
      if (idle_leak !== 0 || stray_ready !== 0 || offer_err !== 0) begin
         errors++; $display("FAIL single_bus: idle_leak=%0d stray_ready=%0d offer_err=%0d, required 0", idle_leak, stray_ready, offer_err);
      end
   endtask

   task automatic test_two_requesters();
      int seq[$];
      int req_order[4] = '{0, 2, 0, 2};
      do_reset();
      for (int i = 0; i < N; i++) const_arr[i] = $urandom;
      for (int p = 0; p < 2; p++) begin
         add_pkt(0, 2);
         add_pkt(2, 2);
      end
      model_build();
      run_engine(0, exp_q.size(), 100);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL two_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            errors++; $display("FAIL two_beat%0d: got %h required %h", k, obs_q[k], exp_q[k]);
         end
         if (obs_q[k].last) seq.push_back(int'(obs_q[k].gid));
      end
      for (int p = 0; p < 4; p++) begin
         checks++;
         if (p >= seq.size() || seq[p] !== req_order[p]) begin
            errors++; $display("FAIL two_order%0d: got %0d required %0d", p, (p < seq.size()) ? seq[p] : -1, req_order[p]);
         end
      end
      checks++;
      if (cyc_count !== 12) begin
         errors++; $display("FAIL two_cycles: got %0d cycles, required 12", cyc_count);
      end
   endtask

   task automatic test_all_requesters();
      int seq[$];
      int last_pos [N];
      int max_gap;
      do_reset();
      for (int i = 0; i < N; i++) begin
         const_arr[i] = $urandom;
         last_pos[i]  = -1;
      end
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < N; i++) add_pkt(i, $urandom_range(1, 3));
      model_build();
      run_engine(0, exp_q.size(), 200);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL all_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            errors++; $display("FAIL all_beat%0d: got %h required %h", k, obs_q[k], exp_q[k]);
         end
         if (obs_q[k].last) seq.push_back(int'(obs_q[k].gid));
      end
      max_gap = 0;
      for (int p = 0; p < 8; p++) begin
         checks++;
         if (p >= seq.size() || seq[p] !== p % N) begin
            errors++; $display("FAIL all_order%0d: got %0d required %0d", p, (p < seq.size()) ? seq[p] : -1, p % N);
         end else begin
            if (p - last_pos[seq[p]] > max_gap) max_gap = p - last_pos[seq[p]];
            last_pos[seq[p]] = p;
         end
      end
      checks++;
      if (max_gap > N) begin
         errors++; $display("FAIL all_starve: longest wait %0d packets, required at most %0d", max_gap - 1, N - 1);
      end
      checks++;
      if (cyc_count !== exp_q.size() + 8) begin
         errors++; $display("FAIL all_cycles: got %0d, required %0d", cyc_count, exp_q.size() + 8);
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < N; i++) const_arr[i] = $urandom;
      add_pkt(3, 4);
      model_build();
      tick = 3;
      run_engine(1, exp_q.size(), 100);
      checks++;
      if (obs_q.size() !== 4) begin
         errors++; $display("FAIL bp_count: got %0d beats, required 4", obs_q.size());
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            errors++; $display("FAIL bp_beat%0d: got %h required %h", k, obs_q[k], exp_q[k]);
         end
      end
      checks++;
      if (stray_ready !== 0 || offer_err !== 0 || idle_leak !== 0) begin
         errors++; $display("FAIL bp_bus: stray_ready=%0d offer_err=%0d idle_leak=%0d, required 0", stray_ready, offer_err, idle_leak);
      end
   endtask

   task automatic test_constant_change();
      for (int i = 0; i < N; i++) const_arr[i] = $urandom;
      const_arr[0] = 32'd7;
      add_pkt(0, 4);
      add_pkt(0, 3);
      model_build();
      for (int k = 4; k < exp_q.size(); k++) exp_q[k].cst = 32'd9;
      chg_at  = 2;
      chg_val = 32'd9;
      run_engine(0, exp_q.size(), 100);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL const_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (obs_q[k].cst !== exp_q[k].cst || obs_q[k] !== exp_q[k]) begin
            errors++; $display("FAIL const_beat%0d: got const %0d required %0d", k, obs_q[k].cst, exp_q[k].cst);
         end
      end
   endtask

   task automatic test_reset_mid_packet();
      for (int i = 0; i < N; i++) const_arr[i] = $urandom;
      add_pkt(2, 2);
      model_build();
      run_engine(0, exp_q.size(), 50);
      add_pkt(2, 5);
      model_build();
      run_engine(0, 1, 50);
      aresetn = 1'b0;
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      for (int i = 0; i < N; i++) txq[i].delete();
      drive_inputs(0);
      model_ptr = 0;
      @(negedge aclk);
      checks++;
      if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || grant_id !== '0 || ctrl_constant !== '0 || dut.rr_ptr !== '0) begin
         errors++;
         $display("FAIL midreset_state: tvalid=%b busy=%b grant=%0d ctrl=%h rr_ptr=%0d, required all 0",
                  m_axis_tvalid, busy, grant_id, ctrl_constant, dut.rr_ptr);
      end
      @(posedge aclk);
      #1;
      add_pkt(0, 2);
      add_pkt(3, 2);
      model_build();
      run_engine(0, exp_q.size(), 100);
      checks++;
      if (obs_q.size() !== 4 || obs_q[0].gid !== '0) begin
         errors++; $display("FAIL midreset_first: beats=%0d first grant=%0d, required 4 beats from grant 0",
                            obs_q.size(), (obs_q.size() > 0) ? int'(obs_q[0].gid) : -1);
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            errors++; $display("FAIL midreset_beat%0d: got %h required %h", k, obs_q[k], exp_q[k]);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < N; i++) begin
         const_arr[i] = $urandom;
         for (int p = $urandom_range(0, 3); p > 0; p--) add_pkt(i, $urandom_range(1, 4));
      end
      add_pkt($urandom_range(0, N-1), 1);
      model_build();
      run_engine(2, exp_q.size(), 3000);
      checks++;
      if (obs_q.size() !== exp_q.size()) begin
         errors++; $display("FAIL b2b_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
      end
      for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
         checks++;
         if (obs_q[k] !== exp_q[k]) begin
            errors++; $display("FAIL b2b_beat%0d: got %h required %h", k, obs_q[k], exp_q[k]);
         end
      end
      checks++;
      if (stray_ready !== 0 || offer_err !== 0 || idle_leak !== 0) begin
         errors++; $display("FAIL b2b_bus: stray_ready=%0d offer_err=%0d idle_leak=%0d, required 0", stray_ready, offer_err, idle_leak);
      end
      checks++;
      if (dut.rr_ptr !== IW'(model_ptr)) begin
         errors++; $display("FAIL b2b_ptr: rr_ptr=%0d required %0d", dut.rr_ptr, model_ptr);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

   initial begin
      aresetn       = 1'b0;
      m_axis_tready = 1'b0;
      req_constant  = '0;
      s_axis_tvalid = '0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tlast  = '0;
      test_reset();
      test_single_requester();
      test_two_requesters();
      test_all_requesters();
      test_backpressure();
      test_constant_change();
      test_reset_mid_packet();
      for (int r = 0; r < 3; r++) test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/adder_stream_arbiter.md
Name: adder_stream_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one pipelined AXI4-Stream constant adder among C_NUM_REQ requester streams.
- Each requester supplies its own add constant. The arbiter drives the adder's ctrl_constant for the duration of the granted packet.
- Sits directly upstream of the adder kernel's s_axis port, in the same clock domain as that port.

Parameters:
- C_NUM_REQ, 4, number of requester streams (2..16).
- C_AXIS_TDATA_WIDTH, 512, tdata width of every stream.
- C_ADDER_BIT_WIDTH, 32, width of each per-requester constant.
- C_ID_WIDTH, 2, grant-index width; must equal clog2(C_NUM_REQ), minimum 1.

Ports:
- aclk  in  1  sole clock; all logic on posedge.
- aresetn  in  1  synchronous active-low reset.
- req_constant  in  C_NUM_REQ*C_ADDER_BIT_WIDTH  per-requester constant; slice i belongs to requester i.
- s_axis_tvalid  in  C_NUM_REQ  per-requester valid.
- s_axis_tready  out  C_NUM_REQ  per-requester ready.
- s_axis_tdata  in  C_NUM_REQ*C_AXIS_TDATA_WIDTH  per-requester data.
- s_axis_tkeep  in  C_NUM_REQ*C_AXIS_TDATA_WIDTH/8  per-requester keep.
- s_axis_tlast  in  C_NUM_REQ  per-requester last.
- m_axis_tvalid  out  1  to adder s_axis_tvalid.
- m_axis_tready  in  1  from adder s_axis_tready.
- m_axis_tdata  out  C_AXIS_TDATA_WIDTH  to adder.
- m_axis_tkeep  out  C_AXIS_TDATA_WIDTH/8  to adder.
- m_axis_tlast  out  1  to adder.
- ctrl_constant  out  C_ADDER_BIT_WIDTH  to adder ctrl_constant; held for the whole granted packet.
- grant_id  out  C_ID_WIDTH  index of the current or last granted requester.
- busy  out  1  high while in XFER.

Behaviour:
- Clock and reset (already decided): one clock (aclk); reset is synchronous and active-low (aresetn).
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, ctrl_constant=0, busy=0, m_axis_tvalid=0, all s_axis_tready=0.
- FSM, two states:
  - IDLE: if any s_axis_tvalid is high, select the winner by round robin starting at rr_ptr (lowest index at or after rr_ptr, wrapping).
  - On selecting a winner, in the same cycle register grant_id=winner and ctrl_constant=req_constant[winner], then move to XFER.
  - No data moves in IDLE. This gives exactly one bubble cycle per packet.
  - XFER: combinational pass-through from the granted requester.
    - m_axis_tvalid = s_axis_tvalid[grant_id].
    - m_axis_tdata/tkeep/tlast = the granted requester's slices.
    - s_axis_tready[grant_id] = m_axis_tready; all other s_axis_tready = 0.
  - On a beat with m_axis_tvalid & m_axis_tready & m_axis_tlast: rr_ptr <= (grant_id+1) mod C_NUM_REQ, then return to IDLE.
- ctrl_constant and grant_id change only on the IDLE->XFER transition. A req_constant change mid-packet has no effect until the next grant.
- Latency: first beat is offered 1 cycle after the arbitration cycle; zero added latency per beat within a packet.
- Outside XFER, m_axis_tvalid=0 and m_axis_tdata/tkeep/tlast=0.
- Backpressure: m_axis_tready low holds the current beat. The grant is never revoked mid-packet.
- A requester dropping tvalid mid-packet keeps the lock; the arbiter waits.
- A requester asserting tvalid while another holds the grant waits. Its ready stays low.
- Starvation bound: a continuously valid requester is granted within C_NUM_REQ-1 packets.
- Single-beat packets (tlast on the first beat) are legal: XFER lasts 1 cycle when ready is high.
- rr_ptr wraps from C_NUM_REQ-1 to 0.
- Non-power-of-two C_NUM_REQ: indices >= C_NUM_REQ are never granted.
- Reset mid-packet: all state returns to reset values on the next edge. The partial packet is abandoned; the adder and downstream FIFO are reset by the same system reset.

Decomposition:
- Package adder_arb_pkg holds:
  - state enum (ST_IDLE, ST_XFER);
  - the function computing clog2;
  - the round-robin priority-select function (valid vector, pointer -> winner, found).
- One sub-module, rr_priority_select: a combinational rotate, find-first, un-rotate. It is reusable by other kernels.
- The FSM, grant registers and the muxing stay in the top module.

Test Plan:
- Only requester 1 valid; 3-beat packet, data 0x10/0x20/0x30, req_constant[1]=5.
  - Required: IDLE bubble, grant_id=1, ctrl_constant=5 before beat 1, beats forwarded in order, busy deasserts after tlast, rr_ptr=2.
- Requesters 0 and 2 valid continuously with 2-beat packets, rr_ptr=0.
  - Required: grant order 0,2,0,2; each packet preceded by exactly one idle cycle.
- All 4 requesters continuously valid for 8 packets.
  - Required: grant sequence 0,1,2,3,0,1,2,3; no requester waits more than 3 packets.
- m_axis_tready toggling 1,0,0,1 during a 4-beat packet from requester 3.
  - Required: beats held stable while ready=0, no duplication or loss, s_axis_tready[3] mirrors m_axis_tready, other readies stay 0.
- req_constant[0] changed from 7 to 9 mid-packet.
  - Required: ctrl_constant stays 7 until tlast; the next grant to requester 0 shows 9.
- aresetn low for 1 cycle on beat 2 of a 5-beat packet.
  - Required: next cycle m_axis_tvalid=0, busy=0, grant_id=0, ctrl_constant=0; a new arbitration starts from rr_ptr=0.
